regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the single write port of the integer register file. Up to N_REQ write-back sources (ALU, load unit, CSR unit) present valid/ready requests; one winner per cycle is selected round-robin and registered onto the register file's write address/data inputs. A per-register busy vector, set on reservation at issue and cleared on commit, lets decode stall on read-after-write hazards.

## Interface
- REG_SIZE, 32, register width in bits
- NO_OF_REGS, 32, number of architectural registers
- REGW, $clog2(NO_OF_REGS), register address width
- N_REQ, 3, number of write-back requesters (2..8)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  N_REQ  requester i has a write pending
- req_addr_i  in  N_REQ*REGW  packed destination addresses, requester i at bits [i*REGW +: REGW]
- req_data_i  in  N_REQ*REG_SIZE  packed write data, requester i at [i*REG_SIZE +: REG_SIZE]
- req_ready_o  out  N_REQ  one-hot grant; request accepted when valid & ready
- waddr_o  out  REGW  register file write address; 0 means no write
- wdata_o  out  REG_SIZE  register file write data
- rsv_valid_i  in  1  decode reserves a destination this cycle
- rsv_addr_i  in  REGW  reserved destination register
- busy_o  out  NO_OF_REGS  bit r set while register r has an outstanding write

## Operation
- Arbitration: combinational round-robin over req_valid_i; search starts at (last_grant+1) mod N_REQ. At most one ready bit high; ready is 0 for non-valid requesters. If any valid, exactly one grant (no idle cycles under load).
- last_grant updates only on a cycle with a grant; reset value N_REQ-1 so requester 0 has priority first.
- Output register: on accept, waddr_o/wdata_o load the winner's addr/data; with no grant, waddr_o loads 0 and wdata_o holds its value.
- Request to address 0: accepted normally, produces waddr_o=0, i.e. no write.
- Scoreboard: at each edge, busy[rsv_addr_i] set if rsv_valid_i and rsv_addr_i!=0; busy[waddr_o] cleared if waddr_o!=0. Same register set and cleared on one edge: set wins.
- busy_o[0] constant 0.
- Decode never reserves a register already busy (it stalls on busy_o); the bench asserts this. Requests are assumed to carry only reserved addresses.
- Requester obligation: addr/data stable while valid and not ready; valid not dropped before acceptance (asserted in bench).

## Timing
- Reset values: waddr_o=0, wdata_o=0, busy_o=0, last_grant=N_REQ-1; req_ready_o follows req_valid_i combinationally (no state dependency except pointer).
- Latency: request accepted at edge N drives waddr_o/wdata_o during cycle N+1; register file captures at edge N+1; busy bit clears at edge N+1, visible cycle N+2 (same cycle the written value is readable).
- Throughput: one write per cycle sustained.
- Reservation at edge N: busy visible from cycle N+1.
- Reset mid-operation: in-flight write dropped (waddr_o forced 0 asynchronously), all busy bits cleared, pointer reinitialised; pending requests re-arbitrate from requester 0 after release.

## Structure
- Package regfile_ctrl_pkg: REG_SIZE, NO_OF_REGS, REGW defaults and N_REQ default; requester index constants (WB_ALU=0, WB_LSU=1, WB_CSR=2).
- Sub-module rr_arbiter (parameter N; req, grant, pointer update on grant) instantiated once; scoreboard and output register in top.

## Test plan
- Reset then idle: no valids for 10 cycles -> waddr_o=0, busy_o=0, req_ready_o=0 throughout.
- Single request: req 1 writes x5=0xDEADBEEF after reserving x5 -> ready[1] same cycle, waddr_o=5/wdata_o=0xDEADBEEF next cycle, busy_o[5] 1 for two cycles then 0.
- Contention: all three valid continuously with distinct addrs -> grants 0,1,2,0,1,2; each requester waits at most N_REQ-1 cycles.
- Set/clear collision: x7 committing on the edge where decode reserves x7 -> busy_o[7] remains 1.
- x0 handling: reserve x0 and request to x0 with data 0x1234 -> busy_o[0]=0, ready granted, waddr_o stays 0.
- Reset mid-flight: rst_i pulsed while waddr_o=9 and busy_o[9]=1 -> waddr_o=0 and busy_o=0 immediately; first grant after release goes to requester 0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file write-back path.
// Contents: default register width, register count, address width and
// requester count, plus the fixed requester index assignment used by the
// write-back sources (ALU, load/store unit, CSR unit).
package regfile_ctrl_pkg;

    localparam int REG_SIZE_DEF   = 32;
    localparam int NO_OF_REGS_DEF = 32;
    localparam int REGW_DEF       = $clog2(NO_OF_REGS_DEF);
    localparam int N_REQ_DEF      = 3;

    // Requester slots on the write-back arbiter
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   req_i   - N request lines
//   grant_o - one-hot grant, combinational from req_i and the pointer
// The search starts one past the last granted requester, so every active
// requester is served within N cycles. The pointer resets to N-1, which
// gives requester 0 first priority after reset.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_lastGrant;
    logic [PW-1:0] w_winIdx;
    logic          w_anyGrant;

    // Candidate index k positions after the last grant, wrapped modulo N.
    function automatic logic [PW-1:0] candIdx(input logic [PW-1:0] last, input int k);
        int s;
        s = (int'(last) + k) % N;
        return PW'(s);
    endfunction

    // Scan from last+1 around to last; the first active request wins.
    always_comb begin
        grant_o    = '0;
        w_winIdx   = r_lastGrant;
        w_anyGrant = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_anyGrant && req_i[candIdx(r_lastGrant, k)]) begin
                grant_o[candIdx(r_lastGrant, k)] = 1'b1;
                w_winIdx   = candIdx(r_lastGrant, k);
                w_anyGrant = 1'b1;
            end
        end
    end

    // The pointer only moves on cycles that actually granted someone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lastGrant <= PW'(N - 1);
        end else if (w_anyGrant) begin
            r_lastGrant <= w_winIdx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the single register
// file write port.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   req_valid_i    - per-requester write pending
//   req_addr_i     - packed destination addresses (REGW bits each)
//   req_data_i     - packed write data (REG_SIZE bits each)
//   req_ready_o    - one-hot grant; accepted when valid & ready
//   waddr_o        - registered write address, 0 means no write
//   wdata_o        - registered write data
//   rsv_valid_i    - decode reserves rsv_addr_i this cycle
//   rsv_addr_i     - destination being reserved
//   busy_o         - per-register outstanding-write flags
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int REG_SIZE   = REG_SIZE_DEF,
    parameter int NO_OF_REGS = NO_OF_REGS_DEF,
    parameter int REGW       = $clog2(NO_OF_REGS),
    parameter int N_REQ      = N_REQ_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*REGW-1:0]     req_addr_i,
    input  logic [N_REQ*REG_SIZE-1:0] req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [REGW-1:0]           waddr_o,
    output logic [REG_SIZE-1:0]       wdata_o,
    input  logic                      rsv_valid_i,
    input  logic [REGW-1:0]           rsv_addr_i,
    output logic [NO_OF_REGS-1:0]     busy_o
);

    logic [N_REQ-1:0]      w_grant;
    logic [REGW-1:0]       w_selAddr;
    logic [REG_SIZE-1:0]   w_selData;
    logic [NO_OF_REGS-1:0] w_busyNext;

    logic [REGW-1:0]       r_waddr;
    logic [REG_SIZE-1:0]   r_wdata;
    logic [NO_OF_REGS-1:0] r_busy;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_valid_i),
        .grant_o (w_grant)
    );

    // Winner's address/data; the grant is one-hot so an OR-style mux is safe.
    always_comb begin
        w_selAddr = '0;
        w_selData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_selAddr = req_addr_i[i*REGW +: REGW];
                w_selData = req_data_i[i*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // Idle cycles drive address 0 (no write) but keep the last data value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (|w_grant) begin
            r_waddr <= w_selAddr;
            r_wdata <= w_selData;
        end else begin
            r_waddr <= '0;
        end
    end

    // Clear on commit first, then set on reservation so a same-edge
    // set/clear of one register leaves it busy. x0 is never tracked.
    always_comb begin
        w_busyNext = r_busy;
        if (r_waddr != '0) begin
            w_busyNext[r_waddr] = 1'b0;
        end
        if (rsv_valid_i && (rsv_addr_i != '0)) begin
            w_busyNext[rsv_addr_i] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign req_ready_o = w_grant;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign busy_o      = r_busy;

endmodule
